// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts detector matches in back-to-back windows of
// programmable length. Keeps a saturating running total and raises sticky
// alarm/overflow flags for the status and interrupt logic.
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             z_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr_alarm,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_done,
  output logic             alarm,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] total_cnt_reg, total_cnt_next;
  logic [CNT_W-1:0] win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [WIN_W-1:0] cyc_reg, cyc_next;
  logic [WIN_W-1:0] win_len_q_reg, win_len_q_next;
  logic             win_done_reg, win_done_next;
  logic             alarm_reg, alarm_next;
  logic             overflow_reg, overflow_next;
  logic             alarm_set, ovf_set;

  // Window count including the current cycle's detection, clamped at full scale.
  logic             run_full;
  logic [CNT_W-1:0] run_sum;
  assign run_full = (run_cnt_reg == CNT_MAX);
  assign run_sum  = (z_in && !run_full) ? run_cnt_reg + CNT_ONE : run_cnt_reg;

  // Next-state and datapath: window sequencing, saturating counts, flag set/clear.
  always_comb begin
    state_next     = state_reg;
    total_cnt_next = total_cnt_reg;
    win_cnt_next   = win_cnt_reg;
    run_cnt_next   = run_cnt_reg;
    cyc_next       = cyc_reg;
    win_len_q_next = win_len_q_reg;
    win_done_next  = 1'b0;
    alarm_set      = 1'b0;
    ovf_set        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Entry edge only arms a fresh window; z_in is not counted here.
        if (en) begin
          state_next     = RUN;
          win_len_q_next = win_len;
          cyc_next       = '0;
          run_cnt_next   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          // Partial window is dropped without reporting.
          state_next   = IDLE;
          run_cnt_next = '0;
        end else begin
          if (z_in) begin
            if (total_cnt_reg == CNT_MAX) ovf_set = 1'b1;
            else                          total_cnt_next = total_cnt_reg + CNT_ONE;
            if (run_full) ovf_set = 1'b1;
          end
          if (cyc_reg == win_len_q_reg) begin
            // Window end: the detection on this edge belongs to the ending window.
            win_cnt_next   = run_sum;
            win_done_next  = 1'b1;
            run_cnt_next   = '0;
            cyc_next       = '0;
            win_len_q_next = win_len;
            if ((thresh != '0) && (run_sum >= thresh)) alarm_set = 1'b1;
          end else begin
            cyc_next     = cyc_reg + WIN_ONE;
            run_cnt_next = run_sum;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Sticky flags: a set on the same edge as a clear takes priority.
    alarm_next    = alarm_set | (alarm_reg & ~clr_alarm);
    overflow_next = ovf_set | (overflow_reg & ~clr_alarm);
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      total_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      run_cnt_reg   <= '0;
      cyc_reg       <= '0;
      win_len_q_reg <= '0;
      win_done_reg  <= 1'b0;
      alarm_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      total_cnt_reg <= total_cnt_next;
      win_cnt_reg   <= win_cnt_next;
      run_cnt_reg   <= run_cnt_next;
      cyc_reg       <= cyc_next;
      win_len_q_reg <= win_len_q_next;
      win_done_reg  <= win_done_next;
      alarm_reg     <= alarm_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign total_cnt = total_cnt_reg;
  assign win_cnt   = win_cnt_reg;
  assign win_done  = win_done_reg;
  assign alarm     = alarm_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Testbench for seq_match_monitor: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_seq_match_monitor;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             z_in = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [CNT_W-1:0] thresh = '0;
  logic             clr_alarm = 1'b0;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             win_done;
  logic             alarm;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model: unbounded hit counts, clamped only when reported.
  bit m_run, m_done, m_alarm, m_ovf;
  int m_pos, m_len, m_hits, m_total, m_win;

  seq_match_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .z_in(z_in), .win_len(win_len),
    .thresh(thresh), .clr_alarm(clr_alarm), .total_cnt(total_cnt),
    .win_cnt(win_cnt), .win_done(win_done), .alarm(alarm), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_alarm = 0; m_ovf = 0;
    m_pos = 0; m_len = 0; m_hits = 0; m_total = 0; m_win = 0;
  endtask

  task automatic model_edge();
    bit aset, oset;
    aset = 0; oset = 0; m_done = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_len = int'(win_len); m_pos = 0; m_hits = 0; end
    end else if (!en) begin
      m_run = 0; m_hits = 0;
    end else begin
      if (z_in) begin
        if (m_total >= MAX) oset = 1;
        if (m_hits >= MAX) oset = 1;
        m_total++;
        m_hits++;
      end
      if (m_pos == m_len) begin
        m_win  = (m_hits > MAX) ? MAX : m_hits;
        m_done = 1;
        if (thresh != 0 && m_win >= int'(thresh)) aset = 1;
        m_hits = 0; m_pos = 0; m_len = int'(win_len);
      end else begin
        m_pos++;
      end
    end
    m_alarm = aset | (m_alarm & !clr_alarm);
    m_ovf   = oset | (m_ovf & !clr_alarm);
  endtask

  // One clock edge; model follows the inputs seen at that edge, outputs sampled #1 later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; z_in = 1'b0; clr_alarm = 1'b0; thresh = '0; win_len = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (total_cnt !== 0) begin errors++; $display("FAIL reset_total got %0d want 0", total_cnt); end
    checks++; if (win_cnt !== 0) begin errors++; $display("FAIL reset_wincnt got %0d want 0", win_cnt); end
    checks++; if (win_done !== 0) begin errors++; $display("FAIL reset_done got %0d want 0", win_done); end
    checks++; if (alarm !== 0) begin errors++; $display("FAIL reset_alarm got %0d want 0", alarm); end
    checks++; if (overflow !== 0) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    win_len = 8'd7; thresh = '0; en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      z_in = (i == 2 || i == 5);
      tick();
      if (i == 6) begin
        checks++; if (win_done !== 0) begin errors++; $display("FAIL basic_early_done got %0d want 0", win_done); end
      end
    end
    checks++; if (win_cnt !== 2) begin errors++; $display("FAIL basic_wincnt got %0d want 2", win_cnt); end
    checks++; if (win_done !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", win_done); end
    checks++; if (total_cnt !== 2) begin errors++; $display("FAIL basic_total got %0d want 2", total_cnt); end
    checks++; if (alarm !== 0) begin errors++; $display("FAIL basic_alarm got %0d want 0", alarm); end
    z_in = 1'b0;
    tick();
    checks++; if (win_done !== 0) begin errors++; $display("FAIL basic_done_pulse got %0d want 0", win_done); end
    $display("test_basic win_cnt=%0d total=%0d", win_cnt, total_cnt);
  endtask

  task automatic test_threshold();
    do_reset();
    win_len = 8'd7; thresh = 4'd2; en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin z_in = (i == 2 || i == 5); tick(); end
    checks++; if (alarm !== 1) begin errors++; $display("FAIL thr_alarm_w1 got %0d want 1", alarm); end
    for (int i = 0; i < 8; i++) begin z_in = (i == 3); tick(); end
    checks++; if (win_cnt !== 1) begin errors++; $display("FAIL thr_wincnt_w2 got %0d want 1", win_cnt); end
    checks++; if (alarm !== 1) begin errors++; $display("FAIL thr_alarm_w2 got %0d want 1", alarm); end
    z_in = 1'b0; clr_alarm = 1'b1;
    tick();
    clr_alarm = 1'b0;
    checks++; if (alarm !== 0) begin errors++; $display("FAIL thr_clear got %0d want 0", alarm); end
    $display("test_threshold alarm=%0d", alarm);
  endtask

  task automatic test_boundary();
    do_reset();
    win_len = 8'd7; en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin z_in = (i == 7); tick(); end
    checks++; if (win_cnt !== 1) begin errors++; $display("FAIL bnd_end_hit got %0d want 1", win_cnt); end
    for (int i = 0; i < 8; i++) begin z_in = 1'b0; tick(); end
    checks++; if (win_cnt !== 0) begin errors++; $display("FAIL bnd_next_win got %0d want 0", win_cnt); end
    en = 1'b0; tick();
    win_len = '0; en = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      z_in = (i != 1);
      tick();
      checks++; if (win_cnt !== ((i != 1) ? 1 : 0)) begin errors++; $display("FAIL bnd_len0_cnt%0d got %0d want %0d", i, win_cnt, (i != 1) ? 1 : 0); end
      checks++; if (win_done !== 1) begin errors++; $display("FAIL bnd_len0_done%0d got %0d want 1", i, win_done); end
    end
    z_in = 1'b0;
    $display("test_boundary win_cnt=%0d", win_cnt);
  endtask

  task automatic test_saturation();
    do_reset();
    win_len = 8'd31; en = 1'b1;
    tick();
    z_in = 1'b1;
    repeat (20) tick();
    checks++; if (total_cnt !== 15) begin errors++; $display("FAIL sat_total got %0d want 15", total_cnt); end
    checks++; if (overflow !== 1) begin errors++; $display("FAIL sat_ovf got %0d want 1", overflow); end
    z_in = 1'b0;
    repeat (11) tick();
    checks++; if (win_done !== 0) begin errors++; $display("FAIL sat_early_done got %0d want 0", win_done); end
    tick();
    checks++; if (win_cnt !== 15) begin errors++; $display("FAIL sat_wincnt got %0d want 15", win_cnt); end
    z_in = 1'b1; clr_alarm = 1'b1;
    tick();
    checks++; if (overflow !== 1) begin errors++; $display("FAIL sat_set_wins got %0d want 1", overflow); end
    z_in = 1'b0;
    tick();
    clr_alarm = 1'b0;
    checks++; if (overflow !== 0) begin errors++; $display("FAIL sat_clear got %0d want 0", overflow); end
    $display("test_saturation total=%0d win_cnt=%0d", total_cnt, win_cnt);
  endtask

  task automatic test_enable_drop();
    bit pat [4] = '{1, 1, 0, 1};
    do_reset();
    win_len = 8'd7; en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin z_in = pat[i]; tick(); end
    en = 1'b0; z_in = 1'b1;
    tick();
    checks++; if (win_done !== 0) begin errors++; $display("FAIL drop_done got %0d want 0", win_done); end
    checks++; if (win_cnt !== 0) begin errors++; $display("FAIL drop_wincnt got %0d want 0", win_cnt); end
    checks++; if (total_cnt !== 3) begin errors++; $display("FAIL drop_total got %0d want 3", total_cnt); end
    tick();
    checks++; if (total_cnt !== 3) begin errors++; $display("FAIL drop_idle_total got %0d want 3", total_cnt); end
    en = 1'b1; z_in = 1'b0;
    tick();
    repeat (7) tick();
    checks++; if (win_done !== 0) begin errors++; $display("FAIL drop_fresh_early got %0d want 0", win_done); end
    z_in = 1'b1;
    tick();
    checks++; if (win_done !== 1) begin errors++; $display("FAIL drop_fresh_done got %0d want 1", win_done); end
    checks++; if (win_cnt !== 1) begin errors++; $display("FAIL drop_fresh_cnt got %0d want 1", win_cnt); end
    checks++; if (total_cnt !== 4) begin errors++; $display("FAIL drop_fresh_total got %0d want 4", total_cnt); end
    z_in = 1'b0;
    $display("test_enable_drop total=%0d", total_cnt);
  endtask

  task automatic test_async_reset();
    do_reset();
    win_len = 8'd7; thresh = 4'd1; en = 1'b1;
    tick();
    z_in = 1'b1;
    repeat (5) tick();
    checks++; if (total_cnt !== 5) begin errors++; $display("FAIL arst_pre_total got %0d want 5", total_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (total_cnt !== 0) begin errors++; $display("FAIL arst_total got %0d want 0", total_cnt); end
    checks++; if ({win_cnt, win_done, alarm, overflow} !== '0) begin errors++; $display("FAIL arst_outputs got %0h want 0", {win_cnt, win_done, alarm, overflow}); end
    model_reset();
    en = 1'b0; z_in = 1'b0; thresh = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    tick();
    z_in = 1'b1;
    repeat (8) tick();
    checks++; if (win_cnt !== 8) begin errors++; $display("FAIL arst_restart_cnt got %0d want 8", win_cnt); end
    checks++; if (total_cnt !== 8) begin errors++; $display("FAIL arst_restart_total got %0d want 8", total_cnt); end
    z_in = 1'b0;
    $display("test_async_reset win_cnt=%0d", win_cnt);
  endtask

  task automatic test_random();
    int bad;
    bad = errors;
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      win_len = WIN_W'($urandom_range(0, 5));
      for (int c = 0; c < 100; c++) begin
        en        = ($urandom_range(0, 9) != 0);
        z_in      = 1'($urandom_range(0, 1));
        thresh    = CNT_W'($urandom_range(0, 6));
        clr_alarm = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 19) == 0) win_len = WIN_W'($urandom_range(0, 5));
        tick();
        checks++; if (int'(total_cnt) !== ((m_total > MAX) ? MAX : m_total)) begin errors++; $display("FAIL rnd_total c=%0d got %0d want %0d", c, total_cnt, (m_total > MAX) ? MAX : m_total); end
        checks++; if (int'(win_cnt) !== m_win) begin errors++; $display("FAIL rnd_wincnt c=%0d got %0d want %0d", c, win_cnt, m_win); end
        checks++; if (win_done !== m_done) begin errors++; $display("FAIL rnd_done c=%0d got %0d want %0d", c, win_done, m_done); end
        checks++; if (alarm !== m_alarm) begin errors++; $display("FAIL rnd_alarm c=%0d got %0d want %0d", c, alarm, m_alarm); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got %0d want %0d", c, overflow, m_ovf); end
      end
    end
    clr_alarm = 1'b0;
    $display("test_random new_errors=%0d", errors - bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_threshold();
    test_boundary();
    test_saturation();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_match_monitor.md
Name: seq_match_monitor

Overview:
Downstream consumer of the Moore sequence detector's registered match output z. Counts detections in fixed-length, back-to-back observation windows and keeps a free-running total. Raises a sticky alarm when a window's count reaches a programmable threshold. Sits between the detector and the status/interrupt logic.

Parameters:
CNT_W, 8, width of all detection counters (saturating)
WIN_W, 16, width of window-length control

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  monitoring enable (level)
z_in  input  1  detector match output; each cycle high = one detection
win_len  input  WIN_W  window length minus one (window = win_len+1 cycles)
thresh  input  CNT_W  alarm threshold; 0 disables alarm
clr_alarm  input  1  one-cycle pulse, clears alarm and overflow
total_cnt  output  CNT_W  saturating count of all detections while enabled
win_cnt  output  CNT_W  detection count of last completed window
win_done  output  1  one-cycle pulse: win_cnt updated
alarm  output  1  sticky: a completed window had win_cnt >= thresh
overflow  output  1  sticky: any counter saturated

Behaviour:
- Reset (rst_n=0, async): state=IDLE; total_cnt, win_cnt, run_cnt, cyc, win_len_q = 0; win_done, alarm, overflow = 0.
- FSM states: IDLE, RUN.
- IDLE: counters held. en=1 at posedge -> RUN; same edge: win_len_q<=win_len, cyc<=0, run_cnt<=0. z_in not counted on this edge.
- RUN: en=0 at posedge -> IDLE. Partial window discarded (run_cnt<=0); no win_done; win_cnt and total_cnt hold.
- RUN, en=1, each posedge:
  - z_in=1: total_cnt+1, saturating at 2^CNT_W-1.
  - cyc<win_len_q: cyc+1; run_cnt+z_in, saturating.
  - cyc==win_len_q (window end):
    - win_cnt <= sat(run_cnt+z_in); win_done<=1 for exactly one cycle.
    - run_cnt<=0, cyc<=0, win_len_q<=win_len. New win_len takes effect only here.
- Back-to-back windows; no dead cycle. The z_in on the window-end edge belongs to the ending window.
- win_len=0: every enabled cycle is a window; win_done stays high continuously, win_cnt = z_in of previous cycle.
- Alarm: at window end, if thresh!=0 and sat(run_cnt+z_in) >= thresh -> alarm<=1.
- clr_alarm=1 clears alarm and overflow. If a set condition occurs on the same edge, set wins.
- overflow<=1 when any increment is blocked by saturation; sticky as above.
- total_cnt is never cleared except by reset. thresh is sampled live at window end.
- Latency: a detection on edge N is visible in total_cnt after edge N. win_cnt, win_done, alarm are all visible after the window-end edge.
- Reset mid-window: immediate return to the reset state; any pending window is lost.

Test Plan:
- Basic window: win_len=7, thresh=0, en=1; z_in high on window cycles 2 and 5 -> after 8th RUN edge win_cnt=2, win_done one cycle, total_cnt=2, alarm=0.
- Threshold: thresh=2, same pattern over 2 windows, second window has 1 hit -> alarm=1 after window 1, stays 1 after window 2; clr_alarm pulse -> alarm=0.
- Boundary hit: z_in high only on window-end edge (cyc=7) -> that window win_cnt=1, next window win_cnt=0; win_len=0 with z=1,0,1 -> win_cnt 1,0,1 with continuous win_done.
- Saturation: CNT_W=4, win_len=31, z_in high 20 consecutive cycles -> win_cnt=15, total_cnt=15, overflow=1. clr_alarm with simultaneous saturating increment -> overflow stays 1.
- Enable drop: 3 hits in first 4 cycles of an 8-cycle window, en=0 at cycle 4 -> no win_done, win_cnt unchanged, total_cnt=3. Re-enable -> fresh window from cyc=0.
- Async reset mid-window: rst_n low between edges at cycle 5 -> all outputs 0 immediately. Release followed by en=1 -> counting restarts cleanly.
